timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped programmable down-counter (TC device) at the device end of the CPU–device bridge, window 0x0000_7F00–0x0000_7F0F.
- Receives the word index, write strobe and write data that the bridge forwards on a hit. Returns read data to the bridge and raises an interrupt line into the CPU's hardware-interrupt vector.
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) operation.

Parameters:
- DW, 32, width of PRESET/COUNT registers and data buses.
- PRESET_RST, 0, reset value of PRESET.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- addr  input  2  word index (byte address bits [3:2] from the bridge)
- we  input  1  write strobe, already qualified by the bridge's TC hit
- wd  input  DW  write data
- rd  output  DW  read data, combinational from addr and current registers
- irq  output  1  interrupt request (registered pending flag AND IM)

Behaviour:
- Register map:
  - addr 0 = CTRL, R/W: bit0 EN, bits2:1 MODE, bit3 IM; other bits write-ignored and read 0.
  - addr 1 = PRESET, R/W.
  - addr 2 = COUNT, read-only; writes ignored.
  - addr 3 = reserved; reads 0, writes ignored.
- Reset (async, rst_n=0): CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_pend=0. This gives irq=0 and rd=register selected by addr.
- FSM states: IDLE, LOAD, CNT, INT. All transitions occur on the clock edge.
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE with COUNT held. Otherwise, COUNT>1 -> COUNT<=COUNT-1 and stay. Otherwise (COUNT<=1) -> COUNT<=0, irq_pend<=1, go to INT.
  - INT, MODE=1: -> LOAD; irq_pend<=0, giving a one-cycle pulse.
  - INT, MODE=0 (MODE 2/3 treated as 0): EN<=0 -> IDLE; irq_pend stays 1 until any CTRL write.
- Latency: with PRESET=N≥1, irq rises N+2 edges after the edge that captures the EN=1 write. PRESET=0 behaves as PRESET=1.
- Mode-1 period: N+2 cycles, consisting of INT, LOAD and N cycles in CNT.
- Register writes:
  - A PRESET write during CNT takes effect only at the next LOAD.
  - Any CTRL write clears irq_pend on that edge.
  - A CTRL write with EN=0 forces IDLE on the next edge from any state, and COUNT freezes.
- Simultaneous events:
  - A CPU CTRL write on the same edge as the FSM's mode-0 EN clear: the CPU write wins, and the written EN value is kept.
  - irq_pend set (entering INT) on the same edge as a CTRL write: the CTRL write wins, so irq_pend=0.
- Masking: IM=0 masks only the irq output; irq_pend still follows the rules above and is visible if IM is later set.
- Reset mid-count: immediate return to reset values. There is no pending-IRQ carry-over.
- Arithmetic: unsigned DW-bit. The COUNT<=1 test makes underflow impossible.

Decomposition:
- Shared package holds:
  - register index constants ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2;
  - CTRL bit positions (EN, MODE, IM);
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1;
  - the FSM state enum (2 bits).
- No sub-module. This is a single flat block: register file, read mux and FSM.

Test Plan:
- Reset: hold rst_n=0 mid-count with COUNT=7 -> COUNT=0, CTRL=0, irq=0 immediately, without waiting for a clock edge. After release, a read at addr 1 returns PRESET_RST.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, mode0, IM) at edge e0.
  - COUNT reads 5,4,3,2,1 at e2..e6.
  - irq=1 from e7, COUNT=0, CTRL reads 0x8.
  - irq held until a CTRL write of 0x8, after which irq=0 the next cycle.
- Periodic: PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles, first pulse at e5; COUNT sequence 3,2,1,0,(LOAD)3…
- Mask/stop: PRESET=10, CTRL=0x3 (IM=0) -> irq never asserts. Writing CTRL=0x0 at COUNT=6 freezes COUNT=6, state IDLE. Rewriting EN=1 reloads 10.
- Access rules:
  - A write to addr 2 of 0xFFFF is ignored.
  - addr 3 reads 0.
  - A PRESET write of 2 during counting does not alter the current run; the next mode-1 reload uses 2.
- Collisions:
  - Mode 0 with PRESET=1: a CTRL=0x9 write on the INT edge keeps EN=1 and irq_pend=0, and the counter restarts.
  - A CTRL write on the edge entering INT leaves irq=0.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_counter_pkg
//   Shared constants for the TC device: register word indices, CTRL field
//   positions, operating modes and the down-counter FSM state type.
// ---------------------------------------------------------------------------
package timer_counter_pkg;

  // Word indices inside the 16-byte TC window
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL register layout: bit0 EN, bits2:1 MODE, bit3 IM
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  // Operating modes; 2 and 3 behave like one-shot
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tcState_t;

endpackage

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//   Memory-mapped programmable down-counter with one-shot and auto-reload
//   periodic modes, sitting behind the CPU-device bridge.
//
//   Ports:
//     clk    - system clock, all state updates on the rising edge
//     rst_n  - asynchronous active-low reset
//     addr   - word index (byte address bits [3:2])
//     we     - write strobe, already qualified by the bridge hit
//     wd     - write data
//     rd     - read data, combinational from addr and current registers
//     irq    - interrupt request = pending flag AND CTRL.IM
// ---------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int              DW         = 32,
  parameter logic [DW-1:0]   PRESET_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    addr,
  input  logic          we,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          irq
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DW-1:0]     r_preset;
  logic [DW-1:0]     r_count;
  logic              r_irqPend;
  tcState_t          r_state;

  tcState_t          w_nextState;
  logic [DW-1:0]     w_nextCount;
  logic              w_nextPend;
  logic              w_fsmClrEn;
  logic              w_ctrlWr;
  logic              w_stopWr;
  logic              w_en;
  logic              w_periodic;

  assign w_ctrlWr   = we && (addr == ADDR_CTRL);
  assign w_stopWr   = w_ctrlWr && !wd[CTRL_EN_BIT];
  assign w_en       = r_ctrl[CTRL_EN_BIT];
  assign w_periodic = (r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_PERIODIC);

  // Next-state logic for the counting FSM. The CPU has priority over the
  // FSM: any CTRL write drops the pending flag, and a write with EN=0 parks
  // the FSM in IDLE on that same edge with COUNT frozen.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextPend  = r_irqPend;
    w_fsmClrEn  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        w_nextCount = r_preset;
        w_nextState = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_nextState = ST_IDLE;
        end else if (r_count > DW'(1)) begin
          w_nextCount = r_count - DW'(1);
        end else begin
          // COUNT of 0 or 1 both terminate here, so underflow cannot occur
          w_nextCount = '0;
          w_nextPend  = 1'b1;
          w_nextState = ST_INT;
        end
      end
      ST_INT: begin
        if (w_periodic) begin
          w_nextPend  = 1'b0;
          w_nextState = ST_LOAD;
        end else begin
          w_fsmClrEn  = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
    endcase
    if (w_ctrlWr) w_nextPend = 1'b0;
    if (w_stopWr) begin
      w_nextState = ST_IDLE;
      w_nextCount = r_count;
    end
  end

  // FSM state, counter and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_irqPend <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_irqPend <= w_nextPend;
    end
  end

  // CTRL register; a CPU write wins over the one-shot EN clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_ctrlWr) begin
      r_ctrl <= wd[CTRL_W-1:0];
    end else if (w_fsmClrEn) begin
      r_ctrl[CTRL_EN_BIT] <= 1'b0;
    end
  end

  // PRESET register; only sampled by the FSM in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preset <= PRESET_RST;
    end else if (we && (addr == ADDR_PRESET)) begin
      r_preset <= wd;
    end
  end

  // Read mux; unused CTRL bits and the reserved word read as zero
  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd[CTRL_W-1:0] = r_ctrl;
      ADDR_PRESET: rd = r_preset;
      ADDR_COUNT:  rd = r_count;
      default:     rd = '0;
    endcase
  end

  assign irq = r_irqPend & r_ctrl[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//   Self-checking bench for timer_counter: directed scenarios with literal
//   expectations followed by randomized register traffic, all compared
//   every cycle against a behavioural model of the timer.
// ---------------------------------------------------------------------------
module tb_timer_counter;

  localparam logic [31:0] TB_PRESET_RST = 32'h0000_1234;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int nChecks = 0;
  int nPass   = 0;
  bit checkOn = 1'b0;

  // Behavioural model state
  logic [3:0]  mCtrl;
  logic [31:0] mPreset;
  logic [31:0] mCount;
  logic        mPend;
  int          mPhase;

  timer_counter #(
    .DW         (32),
    .PRESET_RST (TB_PRESET_RST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mCtrl   = 4'h0;
    mPreset = TB_PRESET_RST;
    mCount  = 32'h0;
    mPend   = 1'b0;
    mPhase  = PH_IDLE;
  endtask

  function automatic logic [31:0] modelRd(logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, mCtrl};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the timer as seen from the register interface
  task automatic modelStep();
    int          nPhase;
    logic [31:0] nCount;
    logic        nPend;
    logic [3:0]  nCtrl;
    if (!rst_n) begin
      modelReset();
      return;
    end
    nPhase = mPhase;
    nCount = mCount;
    nPend  = mPend;
    nCtrl  = mCtrl;
    if (mPhase == PH_IDLE) begin
      if (mCtrl[0]) nPhase = PH_LOAD;
    end else if (mPhase == PH_LOAD) begin
      nCount = mPreset;
      nPhase = PH_RUN;
    end else if (mPhase == PH_RUN) begin
      if (!mCtrl[0]) nPhase = PH_IDLE;
      else if (mCount > 32'd1) nCount = mCount - 32'd1;
      else begin
        nCount = 32'd0;
        nPend  = 1'b1;
        nPhase = PH_FIRE;
      end
    end else begin
      if (mCtrl[2:1] == 2'd1) begin
        nPend  = 1'b0;
        nPhase = PH_LOAD;
      end else begin
        nCtrl[0] = 1'b0;
        nPhase   = PH_IDLE;
      end
    end
    if (we && addr == 2'd0) begin
      nCtrl = wd[3:0];
      nPend = 1'b0;
      if (!wd[0]) begin
        nPhase = PH_IDLE;
        nCount = mCount;
      end
    end
    if (we && addr == 2'd1) mPreset = wd;
    mPhase = nPhase;
    mCount = nCount;
    mPend  = nPend;
    mCtrl  = nCtrl;
  endtask

  always @(posedge clk) modelStep();
  always @(negedge rst_n) modelReset();

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      nPass++;
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (rst_n && checkOn) begin
      checkOutput("cycle_rd", rd, modelRd(addr));
      checkOutput("cycle_irq", {31'h0, irq}, {31'h0, mPend & mCtrl[3]});
    end
  end

  // Inputs change 2 units after a rising edge and are captured by the next
  task automatic applyStimulus(input logic [1:0] a, input logic w, input logic [31:0] d);
    @(posedge clk);
    #2;
    addr = a;
    we   = w;
    wd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'd2, 1'b0, 32'h0);
  endtask

  // Observe state after the next edge and pin both DUT and model to literals
  task automatic readCheck(string name, logic [1:0] a, logic [31:0] expRd, logic expIrq);
    applyStimulus(a, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput(name, rd, expRd);
    checkOutput({name, "_irq"}, {31'h0, irq}, {31'h0, expIrq});
    checkOutput({name, "_model"}, modelRd(a), expRd);
  endtask

  initial begin
    logic [1:0]  ra;
    logic [31:0] rdat;
    int          r;

    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = 32'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOn = 1'b1;

    $display("[TB] reset values");
    readCheck("rst_preset", 2'd1, TB_PRESET_RST, 1'b0);
    readCheck("rst_ctrl", 2'd0, 32'h0, 1'b0);

    $display("[TB] one-shot PRESET=5");
    applyStimulus(2'd1, 1'b1, 32'd5);
    applyStimulus(2'd0, 1'b1, 32'h9);
    idle(2);
    readCheck("os_e2", 2'd2, 32'd5, 1'b0);
    idle(3);
    readCheck("os_e6", 2'd2, 32'd1, 1'b0);
    readCheck("os_e7", 2'd2, 32'd0, 1'b1);
    readCheck("os_e8_ctrl", 2'd0, 32'h8, 1'b1);
    applyStimulus(2'd0, 1'b1, 32'h8);
    readCheck("os_ack", 2'd0, 32'h8, 1'b0);

    $display("[TB] periodic PRESET=3 then PRESET=2");
    applyStimulus(2'd1, 1'b1, 32'd3);
    applyStimulus(2'd0, 1'b1, 32'hB);
    idle(5);
    readCheck("per_e5", 2'd2, 32'd0, 1'b1);
    readCheck("per_e6", 2'd2, 32'd0, 1'b0);
    readCheck("per_e7", 2'd2, 32'd3, 1'b0);
    applyStimulus(2'd1, 1'b1, 32'd2);
    readCheck("per_e9", 2'd2, 32'd1, 1'b0);
    readCheck("per_e10", 2'd2, 32'd0, 1'b1);
    readCheck("per_e11", 2'd2, 32'd0, 1'b0);
    readCheck("per_e12", 2'd2, 32'd2, 1'b0);
    idle(1);
    readCheck("per_e14", 2'd2, 32'd0, 1'b1);
    applyStimulus(2'd0, 1'b1, 32'h0);
    idle(2);

    $display("[TB] masked run and stop");
    applyStimulus(2'd1, 1'b1, 32'd10);
    applyStimulus(2'd0, 1'b1, 32'h3);
    idle(6);
    applyStimulus(2'd0, 1'b1, 32'h0);
    readCheck("stop_hold", 2'd2, 32'd6, 1'b0);
    readCheck("stop_hold2", 2'd2, 32'd6, 1'b0);
    applyStimulus(2'd0, 1'b1, 32'h1);
    idle(2);
    readCheck("stop_reload", 2'd2, 32'd10, 1'b0);
    applyStimulus(2'd0, 1'b1, 32'h0);

    $display("[TB] access rules");
    applyStimulus(2'd2, 1'b1, 32'hFFFF);
    readCheck("count_ro", 2'd2, 32'd9, 1'b0);
    applyStimulus(2'd3, 1'b1, 32'hFFFF_FFFF);
    readCheck("reserved", 2'd3, 32'h0, 1'b0);
    readCheck("preset_keep", 2'd1, 32'd10, 1'b0);

    $display("[TB] collisions");
    applyStimulus(2'd1, 1'b1, 32'd1);
    applyStimulus(2'd0, 1'b1, 32'h9);
    idle(3);
    applyStimulus(2'd0, 1'b1, 32'h9);
    readCheck("col_int_ctrl", 2'd0, 32'h9, 1'b0);
    idle(2);
    readCheck("col_restart", 2'd2, 32'd0, 1'b1);
    applyStimulus(2'd0, 1'b1, 32'h0);
    idle(1);
    applyStimulus(2'd0, 1'b1, 32'h9);
    idle(2);
    applyStimulus(2'd0, 1'b1, 32'h9);
    readCheck("col_enter", 2'd2, 32'd0, 1'b0);
    readCheck("col_after", 2'd0, 32'h8, 1'b0);

    $display("[TB] reset mid-count");
    applyStimulus(2'd1, 1'b1, 32'd10);
    applyStimulus(2'd0, 1'b1, 32'h9);
    idle(5);
    readCheck("pre_rst", 2'd2, 32'd7, 1'b0);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_async_count", rd, 32'h0);
    addr = 2'd0;
    #1 checkOutput("rst_async_ctrl", rd, 32'h0);
    checkOutput("rst_async_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    readCheck("rst_preset2", 2'd1, TB_PRESET_RST, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        we    = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end else if (r < 22) begin
        ra = 2'($urandom_range(0, 3));
        if (ra == 2'd0) begin
          rdat = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) != 0) rdat[0] = 1'b1;
        end else if (ra == 2'd1) begin
          rdat = 32'($urandom_range(0, 8));
        end else begin
          rdat = $urandom;
        end
        applyStimulus(ra, 1'b1, rdat);
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), 1'b0, $urandom);
      end
    end
    applyStimulus(2'd2, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOn = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
